// File: rtl/reg_file_scoreboard_pkg.sv
// reg_file_scoreboard_pkg: shared defaults and constants for the register file scoreboard.
package reg_file_scoreboard_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRP_DEF = 2;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_file_scoreboard_popcount_n.sv
// popcount_n: combinational population count of a W-bit vector.
module popcount_n #(
  parameter int W = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(in_i[i]);
  end
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 2W/NRP-read register file with per-register pending (scoreboard) bits.
// Optional same-cycle write-to-read forwarding under macro REGFILE_BYPASS_EN.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP = NRP_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_num,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                we0,
  input  logic [AW-1:0]       wnum0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       wnum1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_num,
  output logic                iss_ready,
  output logic [AW:0]         busy_cnt
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic [AW:0] busy_cnt_q, cnt_d;
  logic iss_acc;
  assign iss_ready = (iss_num == AW'(ZERO_REG)) || !pending_q[iss_num];
  assign iss_acc = iss_valid && iss_ready;
  assign busy_cnt = busy_cnt_q;
  // Set after clears so a new producer overrides a same-cycle completion.
  always_comb begin
    pending_d = pending_q;
    if (we0) pending_d[wnum0] = 1'b0;
    if (we1) pending_d[wnum1] = 1'b0;
    if (iss_acc) pending_d[iss_num] = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
  end
  popcount_n #(.W(NREG), .CW(AW + 1)) u_pop (.in_i(pending_d), .cnt_o(cnt_d));
  // Port 1 is written last so it wins a same-register collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pending_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (we0 && wnum0 != AW'(ZERO_REG)) regs_q[wnum0] <= wdata0;
      if (we1 && wnum1 != AW'(ZERO_REG)) regs_q[wnum1] <= wdata1;
      pending_q <= pending_d;
      busy_cnt_q <= cnt_d;
    end
  end
  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_num[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1;
    assign hit0 = rst && we0 && wnum0 == a && a != AW'(ZERO_REG);
    assign hit1 = rst && we1 && wnum1 == a && a != AW'(ZERO_REG);
    assign rd_data[k*XLEN +: XLEN] = hit1 ? wdata1 : hit0 ? wdata0 : regs_q[a];
    assign rd_busy[k] = (hit0 || hit1) ? (iss_acc && iss_num == a) : pending_q[a];
`else
    assign rd_data[k*XLEN +: XLEN] = regs_q[a];
    assign rd_busy[k] = pending_q[a];
`endif
  end
endmodule
